// File: rtl/parking_gate_scheduler_pkg.sv
// Shared types and constants for the parking gate scheduler.
// The state type, slot count and default barrier open time live here.
package parking_pkg;

  localparam int NUM_SLOTS       = 4;
  localparam int OPEN_CYCLES_DEF = 8;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    CLOSE    = 2'd3
  } gate_state_e;

  function automatic logic [2:0] occupiedCount(input logic [3:0] occ);
    occupiedCount = {2'b00, occ[0]} + {2'b00, occ[1]} + {2'b00, occ[2]} + {2'b00, occ[3]};
  endfunction

endpackage

// File: rtl/parking_gate_scheduler_slot_allocator.sv
// Priority encoder returning the lowest-index free slot of a 4-slot lot.
// valid_o is low when every slot is occupied.
module slot_allocator (
  input  logic [3:0] occupancy_i,
  output logic [1:0] index_o,
  output logic       valid_o
);

  // Scan from the top down so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    index_o = 2'd0;
    valid_o = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!occupancy_i[i]) begin
        index_o = 2'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Single-barrier parking lot controller: arbitrates entry/exit requests,
// tracks slot occupancy and times the shared gate.
module parking_gate_scheduler #(
  parameter int NUM_SLOTS   = parking_pkg::NUM_SLOTS,
  parameter int OPEN_CYCLES = parking_pkg::OPEN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  output logic       entry_ack,
  output logic       entry_reject,
  output logic       exit_ack,
  output logic       exit_err,
  output logic [1:0] assigned_slot,
  output logic       gate_open,
  output logic [3:0] parking_slots,
  output logic [2:0] capacity,
  output logic       full_light
);

  import parking_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OPEN_CYCLES - 1);

  gate_state_e      state_q, state_d;
  logic [3:0]       slots_q, slots_d;
  logic [1:0]       assigned_q, assigned_d;
  logic             gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exitNext_q, exitNext_d;
  logic             entryAck_q, entryAck_d;
  logic             entryReject_q, entryReject_d;
  logic             exitAck_q, exitAck_d;
  logic             exitErr_q, exitErr_d;

  logic [1:0] allocIdx;
  logic       allocValid;
  logic       serveExit;

  slot_allocator u_slot_allocator (
    .occupancy_i (slots_q),
    .index_o     (allocIdx),
    .valid_o     (allocValid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slots_q       <= '0;
      assigned_q    <= '0;
      gate_q        <= 1'b0;
      cnt_q         <= '0;
      exitNext_q    <= 1'b1;
      entryAck_q    <= 1'b0;
      entryReject_q <= 1'b0;
      exitAck_q     <= 1'b0;
      exitErr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      slots_q       <= slots_d;
      assigned_q    <= assigned_d;
      gate_q        <= gate_d;
      cnt_q         <= cnt_d;
      exitNext_q    <= exitNext_d;
      entryAck_q    <= entryAck_d;
      entryReject_q <= entryReject_d;
      exitAck_q     <= exitAck_d;
      exitErr_q     <= exitErr_d;
    end
  end

  // The ack cycle itself keeps the gate shut; the counter only runs once
  // gate_q is high, so the barrier stays open for exactly OPEN_CYCLES cycles.
  always_comb begin
    state_d       = state_q;
    slots_d       = slots_q;
    assigned_d    = assigned_q;
    gate_d        = 1'b0;
    cnt_d         = cnt_q;
    exitNext_d    = exitNext_q;
    entryAck_d    = 1'b0;
    entryReject_d = 1'b0;
    exitAck_d     = 1'b0;
    exitErr_d     = 1'b0;
    serveExit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        serveExit = exit_req && (!entry_req || exitNext_q);
        if (serveExit) begin
          if (slots_q[exit_slot]) begin
            exitAck_d            = 1'b1;
            slots_d[exit_slot]   = 1'b0;
            cnt_d                = CNT_LOAD;
            exitNext_d           = 1'b0;
            state_d              = OPEN_OUT;
          end else begin
            exitErr_d = 1'b1;
          end
        end else if (entry_req) begin
          if (allocValid) begin
            entryAck_d        = 1'b1;
            slots_d[allocIdx] = 1'b1;
            assigned_d        = allocIdx;
            cnt_d             = CNT_LOAD;
            exitNext_d        = 1'b1;
            state_d           = OPEN_IN;
          end else begin
            entryReject_d = 1'b1;
          end
        end
      end
      OPEN_IN, OPEN_OUT: begin
        gate_d = 1'b1;
        if (gate_q) begin
          if (cnt_q == '0) begin
            gate_d  = 1'b0;
            state_d = CLOSE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      CLOSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign entry_ack     = entryAck_q;
  assign entry_reject  = entryReject_q;
  assign exit_ack      = exitAck_q;
  assign exit_err      = exitErr_q;
  assign assigned_slot = assigned_q;
  assign gate_open     = gate_q;
  assign parking_slots = slots_q;
  assign capacity      = 3'(NUM_SLOTS) - occupiedCount(slots_q);
  assign full_light    = &slots_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Self-checking bench for parking_gate_scheduler: directed vector table,
// hand-written corner sequences and a randomized run against a slot-level model.
module tb_parking_gate_scheduler;

  localparam int OC     = 8;
  localparam int K_NONE = 0;
  localparam int K_EACK = 1;
  localparam int K_EREJ = 2;
  localparam int K_XACK = 3;
  localparam int K_XERR = 4;
  localparam int K_MULTI = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [1:0] exit_slot = 2'd0;
  logic       entry_ack, entry_reject, exit_ack, exit_err;
  logic [1:0] assigned_slot;
  logic       gate_open;
  logic [3:0] parking_slots;
  logic [2:0] capacity;
  logic       full_light;

  int  nChecks = 0;
  int  nFails = 0;
  bit  monEn = 1'b0;
  int  runLen = 0;
  bit  prevPulse = 1'b0;
  bit  prevAck = 1'b0;

  typedef struct {
    bit         entry;
    bit         exitR;
    logic [1:0] slot;
    int         expKind;
    int         expSlot;
    logic [3:0] expOcc;
  } vec_t;

  vec_t vecs[11];
  bit   occ[4];
  bit   exitGoesNext;

  parking_gate_scheduler #(.NUM_SLOTS(4), .OPEN_CYCLES(OC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .exit_slot     (exit_slot),
    .entry_ack     (entry_ack),
    .entry_reject  (entry_reject),
    .exit_ack      (exit_ack),
    .exit_err      (exit_err),
    .assigned_slot (assigned_slot),
    .gate_open     (gate_open),
    .parking_slots (parking_slots),
    .capacity      (capacity),
    .full_light    (full_light)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pulseKind();
    int n;
    n = int'(entry_ack) + int'(entry_reject) + int'(exit_ack) + int'(exit_err);
    if (n > 1) return K_MULTI;
    if (entry_ack) return K_EACK;
    if (entry_reject) return K_EREJ;
    if (exit_ack) return K_XACK;
    if (exit_err) return K_XERR;
    return K_NONE;
  endfunction

  function automatic int freeCount(input logic [3:0] o);
    int f;
    f = 0;
    for (int i = 0; i < 4; i++) if (!o[i]) f++;
    return f;
  endfunction

  function automatic int lowestFree();
    for (int i = 0; i < 4; i++) if (!occ[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] packOcc();
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = occ[i];
    return p;
  endfunction

  // Gate-level watchdog: every open run lasts OC cycles, starts right after an ack,
  // and responses never overlap.
  always @(negedge clk) begin
    int n;
    if (!monEn) begin
      runLen    = 0;
      prevPulse = 1'b0;
      prevAck   = 1'b0;
    end else begin
      n = int'(entry_ack) + int'(entry_reject) + int'(exit_ack) + int'(exit_err);
      if (n != 0) checkOutput("pulse_onehot", n, 1);
      if (prevPulse) checkOutput("gate_after_resp", int'(gate_open), int'(prevAck));
      if (gate_open) runLen++;
      else if (runLen != 0) begin
        checkOutput("gate_run_len", runLen, OC);
        runLen = 0;
      end
      prevPulse = (n != 0);
      prevAck   = entry_ack | exit_ack;
    end
  end

  task automatic applyStimulus(input bit ent, input bit ex, input logic [1:0] slot);
    entry_req = ent;
    exit_req  = ex;
    exit_slot = slot;
  endtask

  task automatic waitPulse(output int kind, output int lat);
    kind = K_NONE;
    lat  = 0;
    for (int c = 0; c < 64 && kind == K_NONE; c++) begin
      @(negedge clk);
      lat++;
      kind = pulseKind();
    end
    if (kind == K_NONE) checkOutput("response_timeout", 0, 1);
  endtask

  task automatic checkOcc(input string name, input logic [3:0] expOcc);
    checkOutput({name, "_occ"}, int'(parking_slots), int'(expOcc));
    checkOutput({name, "_cap"}, int'(capacity), freeCount(expOcc));
    checkOutput({name, "_full"}, int'(full_light), int'(expOcc == 4'b1111));
  endtask

  task automatic applyReset();
    @(negedge clk);
    monEn = 1'b0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_gate", int'(gate_open), 0);
    checkOutput("rst_assigned", int'(assigned_slot), 0);
    checkOutput("rst_pulses", pulseKind(), K_NONE);
    checkOcc("rst", 4'b0000);
    rst_n = 1'b1;
    monEn = 1'b1;
  endtask

  task automatic waitIdle();
    repeat (OC + 4) @(negedge clk);
  endtask

  initial begin
    int kind, lat, expKind, free;
    bit entPend, exPend, serveExit, doEnt, doEx;
    logic [1:0] slot;

    vecs[0]  = '{1'b1, 1'b0, 2'd0, K_EACK, 0, 4'b0001};
    vecs[1]  = '{1'b0, 1'b1, 2'd3, K_XERR, 0, 4'b0001};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, K_EACK, 1, 4'b0011};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, K_EACK, 2, 4'b0111};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, K_EACK, 3, 4'b1111};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, K_EREJ, 0, 4'b1111};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, K_XACK, 0, 4'b1011};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, K_EACK, 2, 4'b1111};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, K_XACK, 0, 4'b1110};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, K_XERR, 0, 4'b1110};
    vecs[10] = '{1'b1, 1'b0, 2'd0, K_EACK, 0, 4'b1111};

    // First entry after reset: ack one cycle after the request is seen in IDLE.
    applyReset();
    applyStimulus(1'b1, 1'b0, 2'd0);
    waitPulse(kind, lat);
    entry_req = 1'b0;
    checkOutput("first_kind", kind, K_EACK);
    checkOutput("first_latency", lat, 1);
    checkOutput("first_slot", int'(assigned_slot), 0);
    checkOcc("first", 4'b0001);
    waitIdle();

    // Directed vector table.
    applyReset();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].entry, vecs[i].exitR, vecs[i].slot);
      waitPulse(kind, lat);
      applyStimulus(1'b0, 1'b0, vecs[i].slot);
      checkOutput($sformatf("vec%0d_kind", i), kind, vecs[i].expKind);
      if (vecs[i].expKind == K_EACK)
        checkOutput($sformatf("vec%0d_slot", i), int'(assigned_slot), vecs[i].expSlot);
      checkOcc($sformatf("vec%0d", i), vecs[i].expOcc);
      if (vecs[i].expKind == K_EACK || vecs[i].expKind == K_XACK) begin
        waitIdle();
      end else begin
        repeat (3) begin
          @(negedge clk);
          checkOutput($sformatf("vec%0d_gate_shut", i), int'(gate_open), 0);
        end
      end
    end

    // Simultaneous requests: exit has priority straight after reset.
    applyReset();
    applyStimulus(1'b1, 1'b1, 2'd1);
    waitPulse(kind, lat);
    exit_req = 1'b0;
    checkOutput("rr_reset_first", kind, K_XERR);
    waitPulse(kind, lat);
    entry_req = 1'b0;
    checkOutput("rr_reset_second", kind, K_EACK);
    checkOutput("rr_reset_second_lat", lat, 1);
    checkOcc("rr_reset", 4'b0001);
    waitIdle();

    // Last grant was an entry, so the exit wins; entry follows after CLOSE.
    applyStimulus(1'b1, 1'b1, 2'd0);
    waitPulse(kind, lat);
    exit_req = 1'b0;
    checkOutput("rr_exit_first", kind, K_XACK);
    checkOcc("rr_exit_first", 4'b0000);
    waitPulse(kind, lat);
    entry_req = 1'b0;
    checkOutput("rr_entry_second", kind, K_EACK);
    checkOutput("rr_entry_after_close", int'(lat >= OC + 2), 1);
    checkOutput("rr_gate_low_between", int'(gate_open), 0);
    checkOutput("rr_entry_slot", int'(assigned_slot), 0);
    checkOcc("rr_entry_second", 4'b0001);
    waitIdle();

    // Reset in the 4th open cycle closes the gate and wipes occupancy.
    applyReset();
    applyStimulus(1'b1, 1'b0, 2'd0);
    waitPulse(kind, lat);
    entry_req = 1'b0;
    checkOutput("midrst_kind", kind, K_EACK);
    repeat (4) @(negedge clk);
    checkOutput("midrst_gate_4th", int'(gate_open), 1);
    monEn = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_gate", int'(gate_open), 0);
    checkOutput("midrst_assigned", int'(assigned_slot), 0);
    checkOcc("midrst", 4'b0000);
    rst_n = 1'b1;

    // Randomized traffic against a slot-level model.
    applyReset();
    for (int i = 0; i < 4; i++) occ[i] = 1'b0;
    exitGoesNext = 1'b1;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 2))
        0: begin doEnt = 1'b1; doEx = 1'b0; end
        1: begin doEnt = 1'b0; doEx = 1'b1; end
        default: begin doEnt = 1'b1; doEx = 1'b1; end
      endcase
      slot = 2'($urandom_range(0, 3));
      applyStimulus(doEnt, doEx, slot);
      entPend = doEnt;
      exPend  = doEx;
      while (entPend || exPend) begin
        waitPulse(kind, lat);
        serveExit = exPend && (!entPend || exitGoesNext);
        free = lowestFree();
        if (serveExit) expKind = occ[slot] ? K_XACK : K_XERR;
        else expKind = (free < 0) ? K_EREJ : K_EACK;
        checkOutput("rnd_kind", kind, expKind);
        if (kind != expKind) begin
          applyStimulus(1'b0, 1'b0, slot);
          entPend = 1'b0;
          exPend  = 1'b0;
        end else begin
          if (serveExit) begin
            exit_req = 1'b0;
            exPend   = 1'b0;
            if (expKind == K_XACK) begin
              occ[slot]    = 1'b0;
              exitGoesNext = 1'b0;
            end
          end else begin
            entry_req = 1'b0;
            entPend   = 1'b0;
            if (expKind == K_EACK) begin
              checkOutput("rnd_slot", int'(assigned_slot), free);
              occ[free]    = 1'b1;
              exitGoesNext = 1'b1;
            end
          end
          checkOcc("rnd", packOcc());
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
